// File: rtl/fp_operand_issuer_if.sv
// fp_operand_issuer_if: host push, a/b operand and c result channels of the fp operand issuer
interface fp_operand_issuer_if #(parameter int DATA_W = 32);
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] a;
  logic              a_valid;
  logic              a_ready;
  logic [DATA_W-1:0] b;
  logic              b_valid;
  logic              b_ready;
  logic [DATA_W-1:0] c;
  logic              c_valid;
  logic              c_ready;
  modport master (
    input  in_a, in_b, in_valid, a_ready, b_ready, c, c_valid,
    output in_ready, a, a_valid, b, b_valid, c_ready
  );
  modport slave (
    output in_a, in_b, in_valid, a_ready, b_ready, c, c_valid,
    input  in_ready, a, a_valid, b, b_valid, c_ready
  );
endinterface

// File: rtl/fp_operand_issuer.sv
// fp_operand_issuer: buffers operand pairs, issues them on a/b channels under a credit limit, sinks results
module fp_operand_issuer #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 8,
  parameter int MAX_OUT = 4
) (
  input  logic              clk,
  input  logic              rst,
  fp_operand_issuer_if.master bus,
  output logic [31:0]       result_count,
  output logic [DATA_W-1:0] last_c,
  output logic [7:0]        outstanding,
  output logic              err_unexpected,
  output logic              busy
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t state;
  logic [2*DATA_W-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, count;
  logic [AW-1:0] head_idx;
  logic [2*DATA_W-1:0] head;
  logic push, res, comp, load_idle, chain;
  assign count        = wr_ptr - rd_ptr;
  assign bus.in_ready = count != (AW+1)'(DEPTH);
  assign push         = bus.in_valid & bus.in_ready;
  assign res          = bus.c_valid & bus.c_ready;
  assign comp         = state == ISSUE && (!bus.a_valid || bus.a_ready) && (!bus.b_valid || bus.b_ready);
  assign load_idle    = state == IDLE && count != '0 && outstanding < 8'(MAX_OUT);
  // back-to-back reload must respect the credit limit after this cycle's completion and result
  assign chain        = comp && count >= (AW+1)'(2) &&
                        ({1'b0, outstanding} + 9'd1 - {8'd0, res}) < 9'(MAX_OUT);
  assign head_idx     = rd_ptr[AW-1:0] + AW'(comp);
  assign head         = mem[head_idx];
  assign busy         = count != '0 || state == ISSUE || outstanding != '0;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= {bus.in_a, bus.in_b};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      bus.a          <= '0;
      bus.b          <= '0;
      bus.a_valid    <= 1'b0;
      bus.b_valid    <= 1'b0;
      bus.c_ready    <= 1'b0;
      result_count   <= '0;
      last_c         <= '0;
      outstanding    <= '0;
      err_unexpected <= 1'b0;
    end else begin
      bus.c_ready <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (comp) rd_ptr <= rd_ptr + 1'b1;
      if (load_idle || chain) begin
        bus.a       <= head[2*DATA_W-1:DATA_W];
        bus.b       <= head[DATA_W-1:0];
        bus.a_valid <= 1'b1;
        bus.b_valid <= 1'b1;
        state       <= ISSUE;
      end else begin
        if (bus.a_valid && bus.a_ready) bus.a_valid <= 1'b0;
        if (bus.b_valid && bus.b_ready) bus.b_valid <= 1'b0;
        if (comp) state <= IDLE;
      end
      if (res) begin
        last_c       <= bus.c;
        result_count <= result_count + 32'd1;
      end
      if (comp && !res) outstanding <= outstanding + 8'd1;
      else if (res && !comp) begin
        if (outstanding == '0) err_unexpected <= 1'b1;
        else outstanding <= outstanding - 8'd1;
      end
    end
  end
endmodule
